// File: rtl/clk_alive_gen.sv
// Status-LED generator: a double-pulse heartbeat that proves clock and reset are
// alive, which can be overridden by a repeating numeric blink code.
module clk_alive_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned PULSE_T     = 100,
  parameter int unsigned GAP_T       = 150,
  parameter int unsigned HB_PERIOD_T = 1000,
  parameter int unsigned PAUSE_T     = 1500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [3:0] code,
  output logic       code_ready,
  input  logic       code_clear,
  output logic       clk_alive,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = 16;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] END_PULSE = CW'(PULSE_T - 1);
  localparam logic [CW-1:0] END_GAP   = CW'(GAP_T - 1);
  localparam logic [CW-1:0] END_IDLE  = CW'(HB_PERIOD_T - 2 * PULSE_T - GAP_T - 1);
  localparam logic [CW-1:0] END_PAUSE = CW'(PAUSE_T - 1);

  typedef enum logic [2:0] {
    HB_ON1,
    HB_OFF1,
    HB_ON2,
    HB_IDLE,
    CODE_ON,
    CODE_OFF,
    CODE_PAUSE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      r_pulse;
  logic [3:0]      w_pulse_nxt;
  logic [3:0]      r_code;
  logic [3:0]      w_code_nxt;
  logic            r_live;
  logic            r_alive;
  logic            r_busy;
  logic            r_ready;
  logic            w_alive_nxt;
  logic            w_busy_nxt;
  logic            w_ready_nxt;
  logic            w_tick;
  logic            w_accept;
  logic            w_in_hb;

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_accept = code_valid && r_ready;
  assign w_in_hb  = (r_state == HB_ON1) || (r_state == HB_OFF1) ||
                    (r_state == HB_ON2) || (r_state == HB_IDLE);

  assign clk_alive  = r_alive;
  assign busy       = r_busy;
  assign code_ready = r_ready;

  // Free-running timebase; only rst_n touches its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HB_IDLE;
      r_cnt   <= '0;
      r_pulse <= '0;
      r_code  <= '0;
      r_live  <= 1'b0;
      r_alive <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_code  <= w_code_nxt;
      r_live  <= 1'b1;
      r_alive <= w_alive_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = r_pulse;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_alive_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_ready_nxt = 1'b0;

    case (r_state)
      HB_ON1:   if (w_tick && (r_cnt == END_PULSE)) w_state_nxt = HB_OFF1;
      HB_OFF1:  if (w_tick && (r_cnt == END_GAP))   w_state_nxt = HB_ON2;
      HB_ON2:   if (w_tick && (r_cnt == END_PULSE)) w_state_nxt = HB_IDLE;
      HB_IDLE:  if (w_tick && (r_cnt == END_IDLE))  w_state_nxt = HB_ON1;
      CODE_ON: begin
        if (w_tick && (r_cnt == END_PULSE)) begin
          if ((r_pulse + 4'd1) == r_code) begin
            w_state_nxt = CODE_PAUSE;
          end else begin
            w_pulse_nxt = r_pulse + 4'd1;
            w_state_nxt = CODE_OFF;
          end
        end
      end
      CODE_OFF: if (w_tick && (r_cnt == END_GAP)) w_state_nxt = CODE_ON;
      CODE_PAUSE: begin
        // A code taken during the pause only matters once the pause ends.
        if (w_accept) w_code_nxt = code;
        if (w_tick && (r_cnt == END_PAUSE)) begin
          if (w_code_nxt != 4'd0) begin
            w_state_nxt = CODE_ON;
            w_pulse_nxt = 4'd0;
          end else begin
            w_state_nxt = HB_ON1;
          end
        end
      end
      default:  w_state_nxt = HB_IDLE;
    endcase

    if (w_accept && w_in_hb && (code != 4'd0)) begin
      w_code_nxt  = code;
      w_pulse_nxt = 4'd0;
      w_state_nxt = CODE_ON;
    end

    if (code_clear) begin
      w_code_nxt  = 4'd0;
      w_state_nxt = HB_ON1;
    end

    if (code_clear || (w_state_nxt != r_state)) begin
      w_cnt_nxt = '0;
    end else if (w_tick) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end

    w_alive_nxt = (w_state_nxt == HB_ON1) || (w_state_nxt == HB_ON2) ||
                  (w_state_nxt == CODE_ON);
    w_busy_nxt  = (w_state_nxt == CODE_ON) || (w_state_nxt == CODE_OFF) ||
                  (w_state_nxt == CODE_PAUSE);
    w_ready_nxt = r_live && ((w_state_nxt == HB_ON1) || (w_state_nxt == HB_OFF1) ||
                             (w_state_nxt == HB_ON2) || (w_state_nxt == HB_IDLE) ||
                             (w_state_nxt == CODE_PAUSE));
  end

endmodule

// File: tb/tb_clk_alive_gen.sv
// Bench for clk_alive_gen: segment-queue reference model plus directed and
// random scenarios on a 10-clock tick.
module tb_clk_alive_gen;

  localparam int DIV   = 10;
  localparam int PULSE = 2;
  localparam int GAP   = 3;
  localparam int HBP   = 20;
  localparam int PAUSE = 8;
  localparam int IDLE  = HBP - 2 * PULSE - GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       code_valid = 1'b0;
  logic [3:0] code = 4'd0;
  logic       code_clear = 1'b0;
  logic       code_ready;
  logic       clk_alive;
  logic       busy;

  int checks = 0;
  int failures = 0;

  clk_alive_gen #(
    .CLK_FREQ_HZ(1000),
    .TICK_HZ    (100),
    .PULSE_T    (PULSE),
    .GAP_T      (GAP),
    .HB_PERIOD_T(HBP),
    .PAUSE_T    (PAUSE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_valid(code_valid),
    .code      (code),
    .code_ready(code_ready),
    .code_clear(code_clear),
    .clk_alive (clk_alive),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the LED pattern is a queue of timed segments.
  typedef struct packed {
    logic        led;
    logic        bsy;
    logic        rdy;
    logic [15:0] len;
  } seg_t;

  seg_t       q[$];
  seg_t       cur;
  int         rem;
  int         m_edges;
  logic       m_live;
  logic       m_rdy;
  logic [3:0] m_code;

  function automatic seg_t mk(logic led, logic bsy, logic rdy, int len);
    seg_t s;
    s.led = led;
    s.bsy = bsy;
    s.rdy = rdy;
    s.len = 16'(len);
    return s;
  endfunction

  task automatic refill();
    if (m_code == 4'd0) begin
      q.push_back(mk(1'b1, 1'b0, 1'b1, PULSE));
      q.push_back(mk(1'b0, 1'b0, 1'b1, GAP));
      q.push_back(mk(1'b1, 1'b0, 1'b1, PULSE));
      q.push_back(mk(1'b0, 1'b0, 1'b1, IDLE));
    end else begin
      for (int i = 1; i <= int'(m_code); i++) begin
        q.push_back(mk(1'b1, 1'b1, 1'b0, PULSE));
        if (i == int'(m_code)) q.push_back(mk(1'b0, 1'b1, 1'b1, PAUSE));
        else                   q.push_back(mk(1'b0, 1'b1, 1'b0, GAP));
      end
    end
  endtask

  task automatic next_seg();
    if (q.size() == 0) refill();
    cur = q.pop_front();
    rem = int'(cur.len);
  endtask

  task automatic model_reset();
    q.delete();
    m_code  = 4'd0;
    cur     = mk(1'b0, 1'b0, 1'b1, IDLE);
    rem     = IDLE;
    m_edges = 0;
    m_live  = 1'b0;
    m_rdy   = 1'b0;
  endtask

  task automatic model_step();
    logic acc, in_hb, in_pause;
    acc      = code_valid && m_rdy;
    in_hb    = !cur.bsy;
    in_pause = cur.bsy && cur.rdy;
    m_edges++;
    if (acc && in_pause) m_code = code;
    if ((m_edges % DIV) == 0) begin
      rem--;
      if (rem == 0) next_seg();
    end
    if (code_clear) begin
      m_code = 4'd0;
      q.delete();
      next_seg();
    end else if (acc && in_hb && (code != 4'd0)) begin
      m_code = code;
      q.delete();
      next_seg();
    end
    m_rdy  = m_live && cur.rdy;
    m_live = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_alive, busy, code_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_values act=%b exp=000", {clk_alive, busy, code_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (code_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_cycle1 act=%b exp=0", code_ready);
    end
    @(negedge clk);
    checks++;
    if (code_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_cycle2 act=%b exp=1", code_ready);
    end
    checks++;
    if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
      failures++;
      $display("FAIL model_reset act=%b exp=%b", {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
    end
  endtask

  task automatic test_heartbeat();
    int  p;
    logic exp;
    for (int k = 3; k <= 450; k++) begin
      @(negedge clk);
      p   = (k - 130) % 200;
      exp = (k >= 130) && ((p < 20) || ((p >= 50) && (p < 70)));
      checks++;
      if (clk_alive !== exp) begin
        failures++;
        $display("FAIL hb_pattern cycle=%0d act=%b exp=%b", k, clk_alive, exp);
      end
      checks++;
      if ({busy, code_ready} !== 2'b01) begin
        failures++;
        $display("FAIL hb_flags cycle=%0d act=%b exp=01", k, {busy, code_ready});
      end
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_hb cycle=%0d act=%b exp=%b", k, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
    end
  endtask

  task automatic test_code3();
    int   pulses;
    logic prev;
    logic done;
    code_valid = 1'b1;
    code       = 4'd3;
    @(negedge clk);
    code_valid = 1'b0;
    checks++;
    if ({clk_alive, busy, code_ready} !== 3'b110) begin
      failures++;
      $display("FAIL code3_accept act=%b exp=110", {clk_alive, busy, code_ready});
    end
    pulses = 1;
    prev   = 1'b1;
    done   = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_code3 t=%0t act=%b exp=%b", $time, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
      if (clk_alive && !prev) pulses++;
      prev = clk_alive;
      if (busy && code_ready) done = 1'b1;
    end
    checks++;
    if (!done || (clk_alive !== 1'b0)) begin
      failures++;
      $display("FAIL code3_pause act=%b exp=1", done && !clk_alive);
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL code3_pulses act=%0d exp=3", pulses);
    end
  endtask

  task automatic test_hold_during_on();
    int   pulses;
    logic prev;
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (clk_alive) seen = 1'b1;
    end
    code_valid = 1'b1;
    code       = 4'd5;
    pulses = 1;
    prev   = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_hold t=%0t act=%b exp=%b", $time, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
      if (clk_alive && !prev) pulses++;
      prev = clk_alive;
      if (code_ready) seen = 1'b1;
    end
    checks++;
    if (!seen || ({clk_alive, busy} !== 2'b01) || (pulses != 3)) begin
      failures++;
      $display("FAIL hold_first_ready act=seen%0b led%b busy%b pulses%0d exp=seen1 led0 busy1 pulses3", seen, clk_alive, busy, pulses);
    end
    @(negedge clk);
    code_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (clk_alive) seen = 1'b1;
    end
    pulses = 1;
    prev   = 1'b1;
    seen   = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_burst5 t=%0t act=%b exp=%b", $time, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
      if (clk_alive && !prev) pulses++;
      prev = clk_alive;
      if (busy && code_ready) seen = 1'b1;
    end
    checks++;
    if (!seen || (pulses != 5)) begin
      failures++;
      $display("FAIL burst5_pulses act=%0d exp=5", pulses);
    end
  endtask

  task automatic test_code0_in_pause();
    int cyc;
    code_valid = 1'b1;
    code       = 4'd0;
    cyc = 0;
    do begin
      @(negedge clk);
      code_valid = 1'b0;
      cyc++;
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_code0 t=%0t act=%b exp=%b", $time, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
    end while (!clk_alive && cyc < 200);
    checks++;
    if (cyc != 80) begin
      failures++;
      $display("FAIL pause_length act=%0d exp=80", cyc);
    end
    checks++;
    if ({clk_alive, busy, code_ready} !== 3'b101) begin
      failures++;
      $display("FAIL pause_to_hb act=%b exp=101", {clk_alive, busy, code_ready});
    end
  endtask

  task automatic test_clear();
    logic seen;
    code_valid = 1'b1;
    code       = 4'd3;
    @(negedge clk);
    code_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (busy && !clk_alive && !code_ready) seen = 1'b1;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || ({clk_alive, busy, code_ready} !== 3'b010)) begin
      failures++;
      $display("FAIL clear_setup_off act=%b exp=010", {clk_alive, busy, code_ready});
    end
    code_clear = 1'b1;
    code_valid = 1'b1;
    code       = 4'd7;
    @(negedge clk);
    code_clear = 1'b0;
    code_valid = 1'b0;
    checks++;
    if ({clk_alive, busy, code_ready} !== 3'b101) begin
      failures++;
      $display("FAIL clear_from_off act=%b exp=101", {clk_alive, busy, code_ready});
    end
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      checks++;
      if ((busy !== 1'b0) || ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy})) begin
        failures++;
        $display("FAIL clear_stays_hb t=%0t act=%b exp=%b", $time, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (!clk_alive && !busy) seen = 1'b1;
    end
    code_clear = 1'b1;
    code_valid = 1'b1;
    code       = 4'd4;
    @(negedge clk);
    code_clear = 1'b0;
    code_valid = 1'b0;
    checks++;
    if ({clk_alive, busy, code_ready} !== 3'b101) begin
      failures++;
      $display("FAIL clear_in_hb act=%b exp=101", {clk_alive, busy, code_ready});
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ((busy !== 1'b0) || ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy})) begin
        failures++;
        $display("FAIL clear_hb_drop t=%0t act=%b exp=%b", $time, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
    end
  endtask

  task automatic test_reset_mid();
    code_valid = 1'b1;
    code       = 4'd2;
    @(negedge clk);
    code_valid = 1'b0;
    checks++;
    if ({clk_alive, busy} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_setup act=%b exp=11", {clk_alive, busy});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_alive, busy, code_ready} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_async act=%b exp=000", {clk_alive, busy, code_ready});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if ((busy !== 1'b0) || ((c < 120) && (clk_alive !== 1'b0))) begin
        failures++;
        $display("FAIL rstmid_resume cycle=%0d act=%b exp=led0 busy0", c, {clk_alive, busy});
      end
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_rstmid cycle=%0d act=%b exp=%b", c, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
    end
  endtask

  task automatic test_random();
    logic taken;
    taken = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      checks++;
      if ({clk_alive, busy, code_ready} !== {cur.led, cur.bsy, m_rdy}) begin
        failures++;
        $display("FAIL model_random cycle=%0d act=%b exp=%b", c, {clk_alive, busy, code_ready}, {cur.led, cur.bsy, m_rdy});
      end
      if (taken) begin
        code_valid = 1'b0;
        taken = 1'b0;
      end
      code_clear = ($urandom_range(0, 299) == 0);
      if (!code_valid && ($urandom_range(0, 99) < 2)) begin
        code_valid = 1'b1;
        code       = 4'($urandom_range(0, 6));
      end
      if (code_valid && code_ready && !code_clear) taken = 1'b1;
    end
    code_valid = 1'b0;
    code_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_code3();
    test_hold_during_on();
    test_code0_in_pause();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_alive_gen.md
Name: clk_alive_gen

Overview:
- Generates the board status-LED drive `clk_alive`, which the top level routes to the `testled` pin.
- Lives inside the block design and runs from the PL fabric clock.
- Default pattern is a "double-pulse" heartbeat that proves the PL clock and reset are alive.
- Software or fabric logic can override the heartbeat with a repeating numeric blink code (1–15 pulses, then a pause) to report faults.

Parameters:
- CLK_FREQ_HZ, 100000000, fabric clock frequency.
- TICK_HZ, 1000, timebase tick rate; DIV = CLK_FREQ_HZ/TICK_HZ, must be an integer ≥ 2.
- PULSE_T, 100, LED-on duration in ticks.
- GAP_T, 150, LED-off duration between pulses in ticks.
- HB_PERIOD_T, 1000, full heartbeat period in ticks; must be ≥ 2*PULSE_T+GAP_T+1.
- PAUSE_T, 1500, LED-off pause after each code burst in ticks.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  asynchronous active-low reset.
- code_valid  in  1  blink-code request valid.
- code  in  4  blink code; 1–15 = pulse count, 0 = return to heartbeat.
- code_ready  out  1  request may be accepted this cycle.
- code_clear  in  1  one-cycle pulse forcing immediate return to heartbeat.
- clk_alive  out  1  LED drive, 1 = on.
- busy  out  1  1 while in any code state.

Behaviour:
- All outputs and state are registered. Reset (rst_n=0, asynchronous) gives: clk_alive=0, busy=0, code_ready=0, prescaler=0, tick counter=0, code_reg=0, state=HB_IDLE.
- Prescaler: counts 0..DIV-1 and wraps. `tick` is high for one cycle when prescaler==DIV-1. The prescaler is never reset except by rst_n.
- Tick counter (16 bit): cleared on every state change and on code acceptance; otherwise increments on tick. A state of duration D exits on the tick where counter==D-1.
- First dwell after entering a state can be short by up to DIV-1 clocks (prescaler phase). This is accepted.
- Heartbeat states:
  - HB_ON1 (PULSE_T) -> HB_OFF1 (GAP_T) -> HB_ON2 (PULSE_T) -> HB_IDLE (HB_PERIOD_T-2*PULSE_T-GAP_T) -> HB_ON1.
- Code states:
  - CODE_ON (PULSE_T) -> CODE_OFF (GAP_T) -> CODE_ON ..., repeated code_reg times.
  - After the code_reg-th CODE_ON -> CODE_PAUSE (PAUSE_T).
  - Pulse counter (4 bit) cleared on entering the first CODE_ON of a burst.
  - CODE_PAUSE end: if code_reg≠0 -> CODE_ON (new burst); if code_reg==0 -> HB_ON1.
- Outputs:
  - clk_alive=1 exactly in HB_ON1, HB_ON2, CODE_ON.
  - busy=1 in CODE_ON, CODE_OFF, CODE_PAUSE.
  - code_ready=1 in all HB states and in CODE_PAUSE; 0 in CODE_ON and CODE_OFF; 0 during reset and the first cycle after release.
- Handshake: a request is accepted when code_valid && code_ready. Only one request per cycle; the requester holds code_valid until accepted.
- Accept in an HB state, code≠0: code_reg<=code; next state CODE_ON; counter cleared. The LED may go 1->1 or 0->1 but never glitches within a cycle.
- Accept in an HB state, code==0: no state change.
- Accept in CODE_PAUSE: code_reg<=code; the pause continues to its full length. The new value (including 0) takes effect at pause end.
- code_clear has priority over everything, including a same-cycle accept (the accept is dropped, code_ready still 1). Next state HB_ON1, counter cleared, code_reg<=0.
- code_clear while already in an HB state: restarts at HB_ON1.
- Reset mid-operation: immediate return to reset values. No pending code survives reset.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 so DIV=10, PULSE_T=2, GAP_T=3, HB_PERIOD_T=20, PAUSE_T=8):
- Reset release, no stimulus:
  - code_ready rises on cycle 2; clk_alive stays 0 for 13 ticks.
  - Then a 20-clock on, 30 off, 20 on, 130 off pattern repeats; 200-clock period; busy=0 throughout.
- code=3 accepted during HB_IDLE:
  - clk_alive shows 3 pulses of 2 ticks separated by 3-tick gaps, then an 8-tick low pause, repeating.
  - busy=1; code_ready=0 except during pauses.
- code_valid=1, code=5 held during CODE_ON:
  - Not accepted until CODE_PAUSE (ready=1 that cycle).
  - The current 3-pulse burst finishes; the next burst has 5 pulses.
- code=0 accepted in CODE_PAUSE:
  - The pause completes its full 8 ticks, then HB_ON1 (clk_alive=1), busy=0.
- code_clear asserted mid-CODE_OFF, same cycle as code_valid:
  - Next cycle: state HB_ON1, clk_alive=1, busy=0, code_reg=0; the request is not taken.
- rst_n pulled low mid-CODE_ON for 1 cycle (asynchronous, between edges):
  - clk_alive, busy and code_ready go 0 immediately.
  - After release the block resumes the heartbeat from HB_IDLE.
